dff_en: RTL and testbench

DFF_EN -- requirements
Module: dff_en

---
 rtl/dff_en.sv | 30 +++
 tb/tb_dff_en.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dff_en.sv
`timescale 1ns/1ps
// Load-enabled D register: a 2:1 recirculation mux ahead of a plain flop,
// cleared asynchronously by an active-low reset.
module dff_en #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d_mux;

    // Hold is done by feeding q back, so the flop itself never needs a clock enable.
    always_comb begin
        d_mux = en ? d : q;
    end

    // Single register stage: q follows the mux one edge after sampling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            q <= d_mux;
        end
    end

endmodule

// File: tb/tb_dff_en.sv
`timescale 1ns/1ps
// Bench for dff_en: a 1-bit and an 8-bit instance share clk/reset/en; expected
// values are queued by the stimulus and compared by an independent monitor.
module tb_dff_en;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       d1;
    logic       q1;
    logic [7:0] d8;
    logic [7:0] q8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
        bit         wide;
    } exp_t;

    exp_t sb[$];

    dff_en #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (en),
        .d      (d1),
        .q      (q1)
    );

    dff_en #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (en),
        .d      (d8),
        .q      (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic at(input longint t);
        if ($time < t) #(t - $time);
    endtask

    task automatic drive(input logic en_v, input logic [7:0] d_v);
        en = en_v;
        d8 = d_v;
        d1 = d_v[0];
    endtask

    task automatic expect_q(input string tag, input logic [7:0] exp8);
        exp_t e1;
        exp_t e8;
        e1.tag  = tag;
        e1.exp  = {7'b0, exp8[0]};
        e1.wide = 1'b0;
        e8.tag  = tag;
        e8.exp  = exp8;
        e8.wide = 1'b1;
        sb.push_back(e1);
        sb.push_back(e8);
    endtask

    // Monitor: consumes expectations as soon as they are posted and samples q then.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            wait (sb.size() != 0);
            e   = sb.pop_front();
            act = e.wide ? q8 : {7'b0, q1};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s (width %0d) at %0t: q=%h expected %h",
                         e.tag, e.wide ? 8 : 1, $time, act, e.exp);
            end
        end
    end

    initial begin
        reset_n = 1'b1;
        drive(1'b1, 8'hFF);

        // Reset held low with en=1, d=1 while the clock runs.
        at(1);   reset_n = 1'b0;
        at(2);   expect_q("reset_state", 8'h00);
        at(7);   expect_q("reset_edge_a", 8'h00);
        at(17);  expect_q("reset_edge_b", 8'h00);

        // Release with en=0; d toggles across edges, q must stay 0.
        at(22);  drive(1'b0, 8'hFF); reset_n = 1'b1;
        at(27);  expect_q("en0_hold_a", 8'h00);
        at(28);  drive(1'b0, 8'h00);
        at(37);  expect_q("en0_hold_b", 8'h00);
        at(38);  drive(1'b0, 8'hFF);
        at(47);  expect_q("en0_hold_c", 8'h00);

        // Loads with en=1, d set 3 ns before each edge.
        at(52);  drive(1'b1, 8'hFF);
        at(54);  expect_q("no_early_load", 8'h00);
        at(57);  expect_q("load_one", 8'hFF);
        at(62);  drive(1'b1, 8'h00);
        at(64);  expect_q("no_transparency", 8'hFF);
        at(67);  expect_q("load_zero", 8'h00);
        at(72);  drive(1'b1, 8'hFF);
        at(77);  expect_q("load_one_again", 8'hFF);

        // Hold with en=0 while d moves, including an en pulse between edges.
        at(82);  drive(1'b0, 8'h00);
        at(87);  expect_q("hold_a", 8'hFF);
        at(90);  drive(1'b0, 8'hFF);
        at(97);  expect_q("hold_b", 8'hFF);
        at(98);  drive(1'b1, 8'h00);
        at(99);  drive(1'b0, 8'hFF);
        at(107); expect_q("en_glitch_hold", 8'hFF);

        // Mid-cycle reset pulse clears at once and stays clear with en=0.
        at(110); reset_n = 1'b0;
        at(111); expect_q("async_clear", 8'h00);
        at(113); reset_n = 1'b1;
        at(117); expect_q("post_reset_hold", 8'h00);

        // Edge during reset with en=1 must not load; first enabled edge after does.
        at(120); reset_n = 1'b0; drive(1'b1, 8'hFF);
        at(127); expect_q("reset_beats_en", 8'h00);
        at(128); reset_n = 1'b1;
        at(131); expect_q("release_no_load", 8'h00);
        at(137); expect_q("first_load", 8'hFF);

        // Multi-bit patterns, en and d changing together.
        at(142); drive(1'b1, 8'hA5);
        at(147); expect_q("load_a5", 8'hA5);
        at(152); drive(1'b0, 8'h3C);
        at(157); expect_q("hold_a5_a", 8'hA5);
        at(167); expect_q("hold_a5_b", 8'hA5);
        at(172); drive(1'b1, 8'h5A);
        at(177); expect_q("load_5a", 8'h5A);
        at(182); drive(1'b1, 8'hFF);
        at(187); expect_q("load_ff", 8'hFF);
        at(192); drive(1'b1, 8'h00);
        at(197); expect_q("load_00", 8'h00);
        at(200); drive(1'b0, 8'h00);

        // Give the monitor a bounded window to drain the queue.
        for (int i = 0; i < 20 && sb.size() != 0; i++) #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
